// File: rtl/byte_uart_tx_pkg.sv
// Shared FSM encoding and 8N1 framing constants for the byte UART transmitter.
// Pure declarations: no latency and no backpressure.
package byte_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/byte_uart_tx_fifo.sv
// Byte FIFO with wrapping pointers and an extra count bit; head is visible combinationally.
// Write-to-count latency is one edge; a push while full is dropped, even with a concurrent pop.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [7:0]               push_dat,
    input  logic                     pop,
    output logic [7:0]               pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        count    = count_q;
        pop_dat  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/byte_uart_tx.sv
// Queues CPU bytes and serialises them as 8N1 frames on a registered, idle-high line.
// Strobe at edge k starts the start bit after edge k+1; bytes strobed while full are dropped with an overflow pulse.
module byte_uart_tx
    import byte_uart_tx_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [7:0]                    in_byte,
    input  logic                          in_byte_en,
    output logic                          uart_tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int                BAUD_W      = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
    localparam logic [2:0]        LAST_BIT    = 3'(UART_DATA_BITS - 1);

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;
    logic              fifo_pop, fifo_empty, baud_done;
    logic [7:0]        fifo_head;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (in_byte_en),
        .push_dat (in_byte),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        baud_done  = (baud_q == '0);
        overflow_d = in_byte_en && fifo_full;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    tx_d     = 1'b0;
                    baud_d   = BAUD_RELOAD;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d = DATA;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Next bit is presented on the line as the register shifts.
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        tx_d     = 1'b0;
                        baud_d   = BAUD_RELOAD;
                        state_d  = START;
                    end else begin
                        tx_d    = 1'b1;
                        baud_d  = '0;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign uart_tx  = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_byte_uart_tx.sv
// Randomised and directed bench for byte_uart_tx against a queue/timeline model of the line.
module tb_byte_uart_tx;
    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic       clk        = 1'b0;
    logic       resetn     = 1'b1;
    logic [7:0] in_byte    = 8'h00;
    logic       in_byte_en = 1'b0;
    logic       uart_tx, busy, fifo_full, overflow;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int ovf_pulses = 0;

    byte_uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_byte    (in_byte),
        .in_byte_en (in_byte_en),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Model: a byte queue plus the position inside the current frame (cycle index after the start edge).
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    logic [7:0] m_byte = 8'h00;
    bit         m_act  = 1'b0;
    bit         m_ovf  = 1'b0;
    int         m_t    = 0;

    initial forever begin
        int         pre;
        bit         en;
        logic [7:0] b;
        @(posedge clk or negedge resetn);
        if (resetn !== 1'b1) begin
            m_q.delete();
            m_act = 1'b0;
            m_ovf = 1'b0;
            m_t   = 0;
        end else begin
            pre = m_q.size();
            en  = in_byte_en;
            b   = in_byte;
            if (m_act && m_t < 10*D - 1) begin
                m_t++;
            end else if (pre != 0) begin
                m_byte = m_q.pop_front();
                m_sent.push_back(m_byte);
                m_act  = 1'b1;
                m_t    = 0;
            end else begin
                m_act = 1'b0;
            end
            m_ovf = en && (pre == DEPTH);
            if (en && pre < DEPTH) m_q.push_back(b);
        end
    end

    function automatic logic exp_tx();
        int idx;
        if (!m_act) return 1'b1;
        idx = m_t / D;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return m_byte[idx-1];
    endfunction

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            chk("uart_tx",    uart_tx,    exp_tx());
            chk("busy",       busy,       m_act || (m_q.size() != 0));
            chk("fifo_count", fifo_count, 32'(m_q.size()));
            chk("fifo_full",  fifo_full,  m_q.size() == DEPTH);
            chk("overflow",   overflow,   m_ovf);
            if (overflow === 1'b1) ovf_pulses++;
        end
    end

    // Line decoder: samples mid-bit from the observed falling start edge.
    logic [7:0] rx_q[$];
    int         rx_start[$];
    bit         d_act = 1'b0;
    int         d_t   = 0;
    logic [7:0] d_sh  = 8'h00;

    always @(negedge clk) begin
        if (resetn !== 1'b1) begin
            d_act <= 1'b0;
        end else if (!d_act) begin
            if (uart_tx === 1'b0) begin
                d_act <= 1'b1;
                d_t   <= 1;
                rx_start.push_back(cyc);
            end
        end else begin
            if (d_t == 9*D + D/2) begin
                chk("stop_bit", uart_tx, 1);
                rx_q.push_back(d_sh);
                d_act <= 1'b0;
            end else if (d_t > D && (d_t % D) == D/2) begin
                d_sh <= {uart_tx, d_sh[7:1]};
            end
            d_t <= d_t + 1;
        end
    end

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_q.size()) return 32'(rx_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int gap_at(input int i);
        if (i + 1 < rx_start.size()) return rx_start[i+1] - rx_start[i];
        return -1;
    endfunction

    task automatic strobe(input logic [7:0] b);
        in_byte    = b;
        in_byte_en = 1'b1;
        @(negedge clk);
        in_byte_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < 4000, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_obs();
        rx_q.delete();
        rx_start.delete();
        m_sent.delete();
        ovf_pulses = 0;
    endtask

    logic [7:0] pa, pb;

    initial begin
        #2 resetn = 1'b0;
        #1;
        chk("rst_tx",    uart_tx,    1);
        chk("rst_busy",  busy,       0);
        chk("rst_full",  fifo_full,  0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf",   overflow,   0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte 0x55 with hand-computed line values.
        clear_obs();
        strobe(8'h55);
        chk("single_k_tx",    uart_tx,    1);
        chk("single_k_count", fifo_count, 1);
        @(negedge clk);
        chk("single_start",  uart_tx,    0);
        chk("single_popped", fifo_count, 0);
        repeat (4) @(negedge clk);
        chk("single_bit0", uart_tx, 1);
        repeat (4) @(negedge clk);
        chk("single_bit1", uart_tx, 0);
        repeat (31) @(negedge clk);
        chk("single_stop",      uart_tx, 1);
        chk("single_busy_last", busy,    1);
        @(negedge clk);
        chk("single_busy_end", busy, 0);
        wait_idle();
        chk("single_n",    rx_q.size(), 1);
        chk("single_byte", rx_at(0),    8'h55);

        // Back-to-back frames, no idle gap.
        clear_obs();
        strobe(8'h41); strobe(8'h42); strobe(8'h43);
        wait_idle();
        chk("b2b_n", rx_q.size(), 3);
        for (int i = 0; i < 3; i++) chk("b2b_byte", rx_at(i), 32'h41 + 32'(i));
        chk("b2b_gap0", gap_at(0), 10*D);
        chk("b2b_gap1", gap_at(1), 10*D);

        // Overflow: sixth consecutive strobe is dropped.
        clear_obs();
        for (int i = 0; i < 6; i++) strobe(8'h60 + 8'(i));
        chk("ovf_now", overflow, 1);
        wait_idle();
        chk("ovf_pulses", ovf_pulses, 1);
        chk("ovf_n", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) chk("ovf_byte", rx_at(i), 32'h60 + 32'(i));

        // Push and pop in the same cycle at count 1.
        clear_obs();
        pa = 8'($urandom);
        pb = 8'($urandom);
        strobe(pa);
        strobe(pb);
        chk("pp_count", fifo_count, 1);
        wait_idle();
        chk("pp_n",  rx_q.size(), 2);
        chk("pp_b0", rx_at(0), 32'(pa));
        chk("pp_b1", rx_at(1), 32'(pb));

        // Reset during data bit 3 of 0xA5, then a clean frame.
        clear_obs();
        strobe(8'hA5);
        repeat (18) @(negedge clk);
        chk("mid_bit3", uart_tx, 0);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_tx",    uart_tx,    1);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_busy",  busy,       0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        clear_obs();
        strobe(8'h0F);
        @(negedge clk);
        chk("post_rst_start", uart_tx, 0);
        wait_idle();
        chk("post_rst_n",    rx_q.size(), 1);
        chk("post_rst_byte", rx_at(0),    8'h0F);

        // Pointer wrap with at most three queued entries.
        clear_obs();
        for (int b = 0; b < 12; b++) begin
            int n = 0;
            while (m_q.size() >= 3 && n < 500) begin
                @(negedge clk);
                n++;
            end
            strobe(8'(b));
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        wait_idle();
        chk("wrap_n", rx_q.size(), 12);
        for (int i = 0; i < 12; i++) chk("wrap_byte", rx_at(i), 32'(i));

        // Random traffic including overflow; decoded stream must match model's pop order.
        clear_obs();
        repeat (1500) begin
            if ($urandom_range(0, 9) == 0) begin
                in_byte    = 8'($urandom);
                in_byte_en = 1'b1;
            end else begin
                in_byte_en = 1'b0;
            end
            @(negedge clk);
        end
        in_byte_en = 1'b0;
        wait_idle();
        chk("rand_n", rx_q.size(), 32'(m_sent.size()));
        for (int i = 0; i < m_sent.size(); i++) chk("rand_byte", rx_at(i), 32'(m_sent[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/byte_uart_tx.md
BYTE_UART_TX -- requirements
Module: byte_uart_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk, resetn.
REQ-002 Parameter CLK_DIV SHALL default to 868 and give clk cycles per UART bit; legal values are integers >= 2.
REQ-003 Parameter FIFO_DEPTH SHALL default to 16 and give FIFO entries; legal values are powers of two >= 2.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 in_byte  input  8  byte from the CPU output port (out_byte at 0x1000_0000).
REQ-007 in_byte_en  input  1  single-cycle strobe; in_byte is valid when high.
REQ-008 uart_tx  output  1  serial line, 8N1, idle high.
REQ-009 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-010 fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 overflow  output  1  one-cycle pulse when a strobed byte is dropped.

Function
REQ-013 A byte with in_byte_en high at edge k SHALL be written to the FIFO at edge k; fifo_count SHALL reflect it after edge k.
REQ-014 A strobe while fifo_full is high SHALL drop the byte, leave FIFO contents unchanged and pulse overflow for exactly one cycle, even if a pop occurs in the same cycle.
REQ-015 Simultaneous push (not full) and pop SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-016 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL use one extra bit so that full and empty are distinguishable.
REQ-017 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-018 IDLE: uart_tx = 1; if the FIFO is non-empty, the FSM SHALL pop the head entry into a shift register and enter START at the next edge.
REQ-019 START: uart_tx = 0 for CLK_DIV cycles, then go to DATA.
REQ-020 DATA: the shift register SHALL be sent LSB first, each bit held CLK_DIV cycles; a 3-bit bit counter SHALL move to STOP after bit 7.
REQ-021 STOP: uart_tx = 1 for CLK_DIV cycles. If the FIFO is non-empty, the FSM SHALL pop and enter START directly with no idle gap; otherwise it returns to IDLE.
REQ-022 Latency: a strobe at edge k into an empty, idle block SHALL drive uart_tx low after edge k+1; the frame SHALL last exactly 10*CLK_DIV cycles.
REQ-023 The baud counter SHALL count CLK_DIV-1 down to 0 and reload on every bit boundary; it SHALL not free-run in IDLE.
REQ-024 uart_tx SHALL be driven from a flop (glitch-free).
REQ-025 busy SHALL be high in START, DATA and STOP, or whenever fifo_count != 0.

Reset
REQ-026 On resetn low, the block SHALL immediately, asynchronously, force: uart_tx=1, busy=0, fifo_full=0, fifo_count=0, overflow=0, FSM=IDLE, pointers and counters=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with the line high; queued bytes are discarded; FIFO storage needs no reset.
REQ-028 After resetn deassertion, the first strobe SHALL behave as in REQ-022.

Structure
REQ-029 FSM state encodings (2 bits) and the 8N1 frame-length constant (10) SHALL live in the shared package/include used by system-level blocks.
REQ-030 The FIFO SHALL be a sub-module named byte_fifo (push/pop/full/empty/count, parameter DEPTH); the FSM and baud counter SHALL remain in byte_uart_tx.
REQ-031 byte_uart_tx SHALL instantiate downstream of system, connecting out_byte/out_byte_en to in_byte/in_byte_en.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-032 Single byte: strobe 0x55 at edge 10 -> uart_tx low over cycles 11-14, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, high stop bit, busy low after edge 51.
REQ-033 Back-to-back: strobe 0x41, 0x42, 0x43 on consecutive cycles -> three frames with no idle gap between stop and start, decoded order A, B, C.
REQ-034 Overflow: 6 strobes on consecutive cycles while idle -> first is popped, 4 queue, sixth dropped with one overflow pulse; decoded output has exactly 5 bytes.
REQ-035 Push and pop in the same cycle at fifo_count=1 -> count stays 1, order preserved.
REQ-036 Reset mid-frame: assert resetn low during DATA bit 3 of 0xA5 -> uart_tx=1 in the same cycle, fifo_count=0; after release, strobe 0x0F transmits correctly.
REQ-037 Wrap-around: 12 sequential bytes 0x00..0x0B, each strobe paced to keep the FIFO at most 3 entries -> all decoded in order across pointer wrap.
